// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port and framed stream bundle for fifo_stream_reader
// master is the drain engine; slave is the FIFO plus downstream sink.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_re;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output fifo_re, m_valid, m_data, m_last,
    input  fifo_r_data, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_re, m_valid, m_data, m_last,
    output fifo_r_data, fifo_empty, m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain engine re-presenting words as a burst-framed stream
// A 2-entry holding buffer hides the FIFO's 1-cycle read latency so a ready sink gets one word per clock.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [15:0]          beat_count,
  output logic                 err_underrun
);

  localparam int BIDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] hold_q [2];
  logic [DATA_WIDTH-1:0] hold_d [2];
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [BIDX_W-1:0]     bidx_q, bidx_d;
  logic [15:0]           beat_q, beat_d;
  logic                  err_q, err_d;

  logic       pop;
  logic       push;
  logic       re;
  logic       wr_idx;
  logic [2:0] level;

  always_comb begin
    pop   = (occ_q != 2'd0) & bus.m_ready;
    push  = inflight_q;
    // Committed words after this cycle's pop; a new read is only allowed if it still fits.
    level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    re    = !rst & en & !bus.fifo_empty & (level < 3'd2);

    // Tail slot as seen after the head shift caused by a simultaneous pop.
    wr_idx = pop ? (occ_q == 2'd2) : (occ_q == 2'd1);

    hold_d     = hold_q;
    occ_d      = occ_q;
    inflight_d = re;
    bidx_d     = bidx_q;
    beat_d     = beat_q;
    err_d      = err_q | (re & bus.fifo_empty);

    if (pop) begin
      hold_d[0] = hold_q[1];
      bidx_d    = (bidx_q == BIDX_LAST) ? '0 : bidx_q + 1'b1;
      beat_d    = beat_q + 16'd1;
    end
    if (push) begin
      hold_d[wr_idx] = bus.fifo_r_data;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q[0]  <= '0;
      hold_q[1]  <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      bidx_q     <= '0;
      beat_q     <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      bidx_q     <= bidx_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign bus.fifo_re  = re;
  assign bus.m_valid  = (occ_q != 2'd0);
  assign bus.m_data   = hold_q[0];
  assign bus.m_last   = (occ_q != 2'd0) & (bidx_q == BIDX_LAST);
  assign beat_count   = beat_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - bench for fifo_stream_reader with cycle vectors and a FIFO model
// Direct-driven vectors first, then a behavioural 8x8 FIFO feeding a scoreboard.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] beat_count;
  logic        err_underrun;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bus          (bus),
    .beat_count   (beat_count),
    .err_underrun (err_underrun)
  );

  logic          use_model, dir_empty, ready, wr_en;
  logic [DW-1:0] dir_data, wr_data, mdl_rdata;
  logic [DW-1:0] mem [8];
  logic [2:0]    wptr, rptr;
  logic [3:0]    cnt;
  logic          wr_ok, rd_ok;

  assign wr_ok = wr_en && (cnt != 4'd8);
  assign rd_ok = bus.fifo_re && (cnt != 4'd0);

  always @(posedge clk) begin
    if (rst) begin
      wptr <= '0; rptr <= '0; cnt <= '0; mdl_rdata <= '0;
    end else begin
      if (wr_ok) begin mem[wptr] <= wr_data; wptr <= wptr + 3'd1; end
      if (rd_ok) begin mdl_rdata <= mem[rptr]; rptr <= rptr + 3'd1; end
      cnt <= cnt + {3'b000, wr_ok} - {3'b000, rd_ok};
    end
  end

  assign bus.fifo_empty  = use_model ? (cnt == 4'd0) : dir_empty;
  assign bus.fifo_r_data = use_model ? mdl_rdata : dir_data;
  assign bus.m_ready     = ready;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] sb_q [$];
  int            sb_beat = 0;
  int            acc = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb_beat = 0;
      acc     = 0;
    end else if (use_model && bus.m_valid && ready) begin
      chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) chk("sb_data", 32'(bus.m_data), 32'(sb_q.pop_front()));
      chk("sb_last", 32'(bus.m_last), 32'((sb_beat % BL) == BL - 1));
      sb_beat++;
      acc++;
    end
  end

  typedef struct {
    logic          en, empty, ready;
    logic [DW-1:0] rdata;
    logic          re, valid;
    logic [DW-1:0] data;
    logic          last;
  } vec_t;

  vec_t tbl [14];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; ready = 1'b0; wr_en = 1'b0;
    step();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic fill8;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      sb_q.push_back(DW'(i));
      step();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_re, first_v, last_v, nvalid, nre, bad, lat, written;
    logic [DW-1:0] vdata;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 8'h33, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 8'h55, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 8'h55, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 8'h00, 1'b0};

    use_model = 1'b0; rst = 1'b1; en = 1'b1; dir_empty = 1'b0; dir_data = '0;
    ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    step();
    #1;
    chk("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_err", 32'(err_underrun), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; dir_empty = tbl[i].empty; ready = tbl[i].ready; dir_data = tbl[i].rdata;
      #1;
      chk($sformatf("vec%0d_re", i), 32'(bus.fifo_re), 32'(tbl[i].re));
      chk($sformatf("vec%0d_valid", i), 32'(bus.m_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d_last", i), 32'(bus.m_last), 32'(tbl[i].last));
      if (tbl[i].valid) chk($sformatf("vec%0d_data", i), 32'(bus.m_data), 32'(tbl[i].data));
      step();
    end
    chk("vec_beat_count", 32'(beat_count), 32'd5);

    // Throughput
    use_model = 1'b1;
    do_reset();
    fill8();
    en = 1'b1; ready = 1'b1;
    first_re = -1; first_v = -1; last_v = -1; nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.fifo_re && first_re < 0) first_re = c;
      if (bus.m_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nvalid++;
      end
      step();
    end
    chk("tp_first_re", 32'(first_re), 32'd0);
    chk("tp_latency", 32'(first_v - first_re), 32'd2);
    chk("tp_nvalid", 32'(nvalid), 32'd8);
    chk("tp_contiguous", 32'(last_v - first_v), 32'd7);
    chk("tp_beat_count", 32'(beat_count), 32'd8);
    chk("tp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure
    do_reset();
    fill8();
    en = 1'b1; ready = 1'b0; nre = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.fifo_re) nre++;
      if (c >= 2 && !(bus.m_valid && bus.m_data == 8'h00)) bad++;
      step();
    end
    chk("bp_re_pulses", 32'(nre), 32'd2);
    chk("bp_hold_stable", 32'(bad), 32'd0);
    ready = 1'b1;
    for (int c = 0; c < 40 && (sb_q.size() != 0 || bus.m_valid); c++) step();
    chk("bp_accepted", 32'(acc), 32'd8);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Random writes and random sink
    do_reset();
    en = 1'b1; written = 0;
    for (int c = 0; c < 6000; c++) begin
      if (written < 300 && cnt < 4'd8 && ($urandom % 2) == 1) begin
        wr_en = 1'b1; wr_data = DW'($urandom_range(0, 255));
        sb_q.push_back(wr_data);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      ready = 1'($urandom % 2);
      step();
      if (written == 300 && sb_q.size() == 0) break;
    end
    wr_en = 1'b0;
    chk("rnd_accepted", 32'(acc), 32'd300);
    chk("rnd_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("rnd_beat_count", 32'(beat_count), 32'd300);
    chk("rnd_err", 32'(err_underrun), 32'd0);

    // Empty source
    do_reset();
    en = 1'b1; ready = 1'b0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.fifo_re || bus.m_valid) bad++;
      step();
    end
    chk("empty_idle", 32'(bad), 32'd0);
    wr_en = 1'b1; wr_data = 8'hA5; sb_q.push_back(8'hA5);
    lat = -1; vdata = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.m_valid && lat < 0) begin lat = c; vdata = bus.m_data; end
      step();
      wr_en = 1'b0;
    end
    chk("empty_latency", 32'(lat), 32'd3);
    chk("empty_data", 32'(vdata), 32'hA5);
    ready = 1'b1;
    step(); step();
    chk("empty_sb_empty", 32'(sb_q.size()), 32'd0);

    // en toggle mid-stream
    do_reset();
    fill8();
    en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 20 && acc < 3; c++) step();
    chk("en_three_pops", 32'(acc), 32'd3);
    en = 1'b0; nre = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.fifo_re) nre++;
      step();
    end
    chk("en_off_no_re", 32'(nre), 32'd0);
    chk("en_off_beats_le2", 32'(acc <= 5), 32'd1);
    en = 1'b1;
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) step();
    chk("en_resume_accepted", 32'(acc), 32'd8);

    // Reset mid-operation
    do_reset();
    fill8();
    en = 1'b1; ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("mid_beat_count_before", 32'(beat_count), 32'd2);
    rst = 1'b1; ready = 1'b0;
    #1;
    chk("mid_re_during_rst", 32'(bus.fifo_re), 32'd0);
    step();
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_m_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_beat_count", 32'(beat_count), 32'd0);
    chk("mid_m_last", 32'(bus.m_last), 32'd0);
    chk("mid_fifo_re", 32'(bus.fifo_re), 32'd0);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      #1;
      if (bus.m_valid) bad++;
    end
    chk("mid_no_stale", 32'(bad), 32'd0);
    chk("final_err", 32'(err_underrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
